// File: rtl/prio_seg_pkg.sv
// Shared constants for the priority encoder / seven-segment display block.
// Segment bytes are active-low, ordered a,b,c,d,e,f,g,dp from bit 7 down to bit 0.
package prio_seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Entry 0 is the rightmost element; dp (bit 0) is always off.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
        8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
    };

    function automatic logic [7:0] hex2seg(input logic [3:0] hex);
        return SEG_TABLE[hex];
    endfunction

endpackage

// File: rtl/vec_debounce.sv
// Two-flop synchroniser followed by a per-vector stability filter.
// The filtered vector updates only after the synchronised input holds one value for DEB_CYCLES+1 edges.
module vec_debounce #(
    parameter int WIDTH      = 8,
    parameter int DEB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_req,
    output logic [WIDTH-1:0] o_filt
);

    localparam logic [7:0] CNT_LAST = 8'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] r_filt;
    logic [7:0]       r_cnt;

    // Synchronise the raw switch inputs into the clock domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= {WIDTH{1'b0}};
            r_s2 <= {WIDTH{1'b0}};
        end else begin
            r_s1 <= i_req;
            r_s2 <= r_s1;
        end
    end

    // Any difference restarts qualification; the count saturates once the candidate is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cand <= {WIDTH{1'b0}};
            r_filt <= {WIDTH{1'b0}};
            r_cnt  <= 8'd0;
        end else if (r_s2 != r_cand) begin
            r_cand <= r_s2;
            r_cnt  <= 8'd0;
        end else if (r_cnt == CNT_LAST) begin
            r_filt <= r_cand;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/prio_enc_seg.sv
// Debounced priority encoder driving a registered index, valid flag,
// seven-segment pattern of the winning index and a count of accepted index changes.
module prio_enc_seg
    import prio_seg_pkg::*;
#(
    parameter int N          = 8,
    parameter int W          = $clog2(N),
    parameter int DEB_CYCLES = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         clr,
    output logic [W-1:0] idx,
    output logic         valid,
    output logic [7:0]   seg0,
    output logic [7:0]   change_cnt
);

    logic [N-1:0] w_filt;
    logic [W-1:0] w_winner;
    logic [W-1:0] w_idx_nxt;
    logic         w_valid_nxt;
    logic [7:0]   w_seg_nxt;
    logic         w_change;

    logic [W-1:0] r_idx;
    logic         r_valid;
    logic [7:0]   r_seg0;
    logic [7:0]   r_change_cnt;

    vec_debounce #(
        .WIDTH      (N),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .i_req  (req),
        .o_filt (w_filt)
    );

    // Scan from lowest to highest priority so the last set bit visited wins.
    always_comb begin
        w_winner = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (MSB_FIRST != 0) begin
                w_winner = w_filt[i] ? W'(i) : w_winner;
            end else begin
                w_winner = w_filt[N-1-i] ? W'(N-1-i) : w_winner;
            end
        end
    end

    // Next output values and whether they count as an accepted index change.
    always_comb begin
        w_valid_nxt = en && (w_filt != {N{1'b0}});
        if (w_valid_nxt) begin
            w_idx_nxt = w_winner;
            w_seg_nxt = hex2seg(4'(w_winner));
        end else begin
            w_idx_nxt = {W{1'b0}};
            w_seg_nxt = SEG_BLANK;
        end
        w_change = w_valid_nxt && (!r_valid || (w_idx_nxt != r_idx));
    end

    // Registered display outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_idx   <= {W{1'b0}};
            r_seg0  <= SEG_BLANK;
        end else begin
            r_valid <= w_valid_nxt;
            r_idx   <= w_idx_nxt;
            r_seg0  <= w_seg_nxt;
        end
    end

    // Change counter: clear beats increment, wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_change_cnt <= 8'd0;
        end else if (clr) begin
            r_change_cnt <= 8'd0;
        end else if (w_change) begin
            r_change_cnt <= r_change_cnt + 8'd1;
        end else begin
            r_change_cnt <= r_change_cnt;
        end
    end

    assign idx        = r_idx;
    assign valid      = r_valid;
    assign seg0       = r_seg0;
    assign change_cnt = r_change_cnt;

endmodule
